// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares one data memory between the core load/store path and
//                a debug/loader port, sequencing each access with wait states.
// Option macro : DMEM_ARB_ROUND_ROBIN_EN (round-robin on contention; default
//                build is fixed priority with the CPU winning contention)
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,

  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,

  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t              state_q,     state_d;
  logic [3:0]          cnt_q,       cnt_d;
  logic                gnt_dbg_q,   gnt_dbg_d;
  logic                first_q,     first_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                pick_dbg;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // 1 = debug port held the most recent grant; reset value makes the CPU win
  // the first contention.
  logic                last_gnt_q,  last_gnt_d;

  always_comb begin
    pick_dbg = dbg_req_i & (~cpu_req_i | ~last_gnt_q);
  end
`else
  always_comb begin
    pick_dbg = dbg_req_i & ~cpu_req_i;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dbg_d   = gnt_dbg_q;
    first_d     = first_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_gnt_d  = last_gnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          gnt_dbg_d = pick_dbg;
          we_d      = pick_dbg ? dbg_we_i    : cpu_we_i;
          addr_d    = pick_dbg ? dbg_addr_i  : cpu_addr_i;
          wdata_d   = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
          cnt_d     = WAIT_INIT;
          first_d   = 1'b1;
          state_d   = S_ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_gnt_d = pick_dbg;
`endif
        end
      end

      S_ACCESS: begin
        first_d = 1'b0;
        if (cnt_q == 4'd0) begin
          // Only the granted port's read register moves; the other holds.
          if (gnt_dbg_q) begin
            dbg_rdata_d = mem_rdata_i;
          end else begin
            cpu_rdata_d = mem_rdata_i;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      gnt_dbg_q   <= 1'b0;
      first_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_dbg_q   <= gnt_dbg_d;
      first_q     <= first_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Strobes decode straight from the state register so an asynchronous reset
  // removes them immediately.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    mem_re_o    = (state_q == S_ACCESS) & ~we_q;
    mem_we_o    = (state_q == S_ACCESS) & we_q & first_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    cpu_ack_o   = (state_q == S_DONE) & ~gnt_dbg_q;
    dbg_ack_o   = (state_q == S_DONE) &  gnt_dbg_q;
    cpu_rdata_o = cpu_rdata_q;
    dbg_rdata_o = dbg_rdata_q;
    cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  end

endmodule

`default_nettype wire
